// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types and defaults for the pipeline hazard unit: tracked-stage entry
// record, forward-select encoding and default parameter values.
`timescale 1ns/1ps
package pipeline_hazard_unit_pkg;
  localparam int ADDR_W_MAX       = 16;
  localparam int DEF_ADDR_W       = 5;
  localparam int DEF_DEPTH        = 3;
  localparam int DEF_LOAD_STAGE   = 2;
  localparam int DEF_BRANCH_STAGE = 2;
  localparam int CNT_W            = 16;
  localparam int SEL_RF           = 0;

  // dst is stored zero-extended so one record type serves any ADDR_W <= ADDR_W_MAX
  typedef struct packed {
    logic                  valid;
    logic                  wr;
    logic [ADDR_W_MAX-1:0] dst;
    logic                  is_load;
  } entry_t;
endpackage

// File: rtl/pipeline_hazard_unit_match.sv
// Per-source match: picks the youngest in-flight producer of a source register
// and flags a load-use stall when that producer's data is not yet available.
`timescale 1ns/1ps
module hazard_match
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LOAD_STAGE = DEF_LOAD_STAGE,
  parameter int SEL_W      = $clog2(DEPTH+1)
) (
  input  entry_t [DEPTH:1]    entries,
  input  logic                id_valid,
  input  logic                used,
  input  logic [ADDR_W-1:0]   src,
  output logic [SEL_W-1:0]    sel,
  output logic                load_stall
);
  logic [ADDR_W_MAX-1:0] src_ext;
  logic                  active;

  assign src_ext = ADDR_W_MAX'(src);
  assign active  = id_valid && used && (src != '0);

  always_comb begin
    sel        = SEL_W'(SEL_RF);
    load_stall = 1'b0;
    // scan oldest to youngest so the youngest match is the one left standing
    for (int k = DEPTH; k >= 1; k--) begin
      if (entries[k].valid && entries[k].wr && entries[k].dst == src_ext) begin
        sel        = SEL_W'(k);
        load_stall = entries[k].is_load && (k < LOAD_STAGE);
      end
    end
    if (!active) begin
      sel        = SEL_W'(SEL_RF);
      load_stall = 1'b0;
    end
    if (load_stall) sel = SEL_W'(SEL_RF);
  end
endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard unit: tracks writing instructions in EX..WB, drives forward selects,
// load-use stall/bubble and branch flush, plus in-flight and stall counters.
`timescale 1ns/1ps
module pipeline_hazard_unit
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int LOAD_STAGE   = DEF_LOAD_STAGE,
  parameter int BRANCH_STAGE = DEF_BRANCH_STAGE,
  parameter int SEL_W        = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [ADDR_W-1:0] id_dst,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              branch_taken,
  output logic              stall_if,
  output logic              bubble_id,
  output logic              flush,
  output logic [SEL_W-1:0]  fwd_rs_sel,
  output logic [SEL_W-1:0]  fwd_rt_sel,
  output logic [SEL_W-1:0]  in_flight,
  output logic [CNT_W-1:0]  stall_cnt
);
  entry_t [DEPTH:1] ent, ent_nxt;
  entry_t           id_ent;
  logic [SEL_W-1:0] rs_sel, rt_sel, cnt_nxt;
  logic             rs_stall, rt_stall;

  hazard_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)) u_rs (
    .entries(ent), .id_valid(id_valid), .used(id_uses_rs), .src(id_rs),
    .sel(rs_sel), .load_stall(rs_stall)
  );

  hazard_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)) u_rt (
    .entries(ent), .id_valid(id_valid), .used(id_uses_rt), .src(id_rt),
    .sel(rt_sel), .load_stall(rt_stall)
  );

  // outputs are forced quiet while reset is held, whatever the inputs do
  assign flush      = rst_n & branch_taken;
  assign stall_if   = rst_n & (rs_stall | rt_stall) & ~branch_taken;
  assign bubble_id  = stall_if;
  assign fwd_rs_sel = rst_n ? rs_sel : SEL_W'(SEL_RF);
  assign fwd_rt_sel = rst_n ? rt_sel : SEL_W'(SEL_RF);

  always_comb begin
    id_ent         = '0;
    id_ent.valid   = 1'b1;
    id_ent.wr      = id_reg_write && (id_dst != '0);
    id_ent.dst     = ADDR_W_MAX'(id_dst);
    id_ent.is_load = id_is_load;

    ent_nxt    = '0;
    ent_nxt[1] = (id_valid && !stall_if && !branch_taken) ? id_ent : '0;
    // younger-than-branch entries die as they shift; the branch itself moves on
    for (int k = 2; k <= DEPTH; k++)
      ent_nxt[k] = (branch_taken && (k-1) < BRANCH_STAGE) ? '0 : ent[k-1];

    cnt_nxt = '0;
    for (int k = 1; k <= DEPTH; k++)
      cnt_nxt = cnt_nxt + SEL_W'(ent_nxt[k].valid & ent_nxt[k].wr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent       <= '0;
      in_flight <= '0;
      stall_cnt <= '0;
    end else begin
      ent       <= ent_nxt;
      in_flight <= cnt_nxt;
      if (stall_if && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench for pipeline_hazard_unit: directed vectors push expected
// outputs, monitors pop and compare at the falling edge.
`timescale 1ns/1ps
module tb_pipeline_hazard_unit;
  logic clk = 1'b0, rst_n = 1'b0, rst_n_sat = 1'b0, probe = 1'b0;
  always #5 clk = ~clk;

  logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_is_load, branch_taken;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       stall_if, bubble_id, flush;
  logic [1:0] fwd_rs_sel, fwd_rt_sel, in_flight;
  logic [15:0] stall_cnt;

  logic       s_stall_if, s_bubble_id, s_flush;
  logic [4:0] s_rs_sel, s_rt_sel, s_in_flight;
  logic [15:0] s_stall_cnt;

  pipeline_hazard_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .branch_taken(branch_taken),
    .stall_if(stall_if), .bubble_id(bubble_id), .flush(flush),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .in_flight(in_flight),
    .stall_cnt(stall_cnt)
  );

  // deep load stage keeps the unit stalling 30 of every 31 cycles
  pipeline_hazard_unit #(.ADDR_W(5), .DEPTH(31), .LOAD_STAGE(31), .BRANCH_STAGE(2)) dut_sat (
    .clk(clk), .rst_n(rst_n_sat), .id_valid(1'b1), .id_rs(5'd5), .id_rt(5'd0),
    .id_uses_rs(1'b1), .id_uses_rt(1'b0), .id_dst(5'd5),
    .id_reg_write(1'b1), .id_is_load(1'b1), .branch_taken(1'b0),
    .stall_if(s_stall_if), .bubble_id(s_bubble_id), .flush(s_flush),
    .fwd_rs_sel(s_rs_sel), .fwd_rt_sel(s_rt_sel), .in_flight(s_in_flight),
    .stall_cnt(s_stall_cnt)
  );

  typedef struct {
    string       name;
    logic        stall;
    logic        flush;
    logic [1:0]  rs_sel;
    logic [1:0]  rt_sel;
    logic [1:0]  in_flight;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] sat_q[$];
  int n_chk = 0, n_fail = 0;

  always @(negedge clk or posedge probe) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_chk++;
      if ({stall_if, bubble_id, flush, fwd_rs_sel, fwd_rt_sel, in_flight, stall_cnt} !==
          {e.stall, e.stall, e.flush, e.rs_sel, e.rt_sel, e.in_flight, e.cnt}) begin
        n_fail++;
        $display("FAIL %s: got stall=%0b bub=%0b flush=%0b rs=%0d rt=%0d infl=%0d cnt=%0h, want stall=%0b bub=%0b flush=%0b rs=%0d rt=%0d infl=%0d cnt=%0h",
                 e.name, stall_if, bubble_id, flush, fwd_rs_sel, fwd_rt_sel, in_flight, stall_cnt,
                 e.stall, e.stall, e.flush, e.rs_sel, e.rt_sel, e.in_flight, e.cnt);
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] w;
    if (sat_q.size() > 0) begin
      w = sat_q.pop_front();
      n_chk++;
      if (s_stall_cnt !== w) begin
        n_fail++;
        $display("FAIL sat_cnt: got %0h, want %0h", s_stall_cnt, w);
      end
    end
  end

  task automatic drv(input logic v, input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                     input logic urt, input logic [4:0] dst, input logic rw, input logic ld,
                     input logic br);
    id_valid = v; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
    id_dst = dst; id_reg_write = rw; id_is_load = ld; branch_taken = br;
  endtask

  task automatic expect_o(input string nm, input logic st, input logic fl, input logic [1:0] rs,
                          input logic [1:0] rt, input logic [1:0] inf, input logic [15:0] cnt);
    exp_t e;
    e.name = nm; e.stall = st; e.flush = fl; e.rs_sel = rs; e.rt_sel = rt;
    e.in_flight = inf; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_main();
    drv(1, 5, 1, 5, 1, 5, 1, 1, 1);
    @(posedge clk); #1;
    expect_o("reset_state", 0, 0, 0, 0, 0, 0); tick();
    rst_n = 1'b1;
    drv(1, 1, 1, 2, 1, 3, 1, 0, 0); expect_o("add_r3",        0, 0, 0, 0, 0, 0); tick();
    drv(1, 3, 1, 0, 1, 6, 1, 0, 0); expect_o("fwd_ex",        0, 0, 1, 0, 1, 0); tick();
    drv(1, 3, 1, 6, 1, 5, 1, 1, 0); expect_o("fwd_mem_ex",    0, 0, 2, 1, 2, 0); tick();
    drv(1, 5, 1, 3, 1, 4, 1, 0, 0); expect_o("load_use",      1, 0, 0, 3, 3, 0); tick();
    drv(1, 5, 1, 3, 1, 4, 1, 0, 0); expect_o("after_stall",   0, 0, 2, 0, 2, 1); tick();
    drv(1, 4, 1, 5, 1, 4, 1, 0, 0); expect_o("fwd_r4_wb",     0, 0, 1, 3, 2, 1); tick();
    drv(1, 4, 1, 0, 1, 0, 1, 0, 0); expect_o("youngest_r4",   0, 0, 1, 0, 2, 1); tick();
    drv(1, 0, 1, 4, 1, 7, 1, 0, 0); expect_o("r0_no_fwd",     0, 0, 0, 2, 2, 1); tick();
    drv(0, 7, 1, 7, 1, 7, 1, 0, 0); expect_o("id_invalid",    0, 0, 0, 0, 2, 1); tick();
    drv(1, 0, 0, 0, 0, 7, 1, 0, 0); expect_o("branch_issue",  0, 0, 0, 0, 1, 1); tick();
    drv(1, 7, 1, 0, 0, 5, 1, 1, 0); expect_o("fwd_r7_young",  0, 0, 1, 0, 2, 1); tick();
    drv(1, 5, 1, 0, 0, 8, 1, 0, 1); expect_o("branch_flush",  0, 1, 0, 0, 2, 1); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_o("post_flush",    0, 0, 0, 0, 1, 1); tick();
    drv(1, 0, 0, 0, 0, 5, 1, 1, 0); expect_o("lw_r5",         0, 0, 0, 0, 0, 1); tick();
    drv(1, 5, 1, 0, 0, 9, 1, 0, 0); expect_o("stall_pre_rst", 1, 0, 0, 0, 1, 1);
    // assert reset in the low phase: no rising edge between assertion and the check
    @(negedge clk); #1;
    rst_n = 1'b0; branch_taken = 1'b1;
    expect_o("async_reset", 0, 0, 0, 0, 0, 0);
    #1 probe = 1'b1;
    #1 probe = 1'b0;
    tick();
    rst_n = 1'b1;
    drv(1, 5, 1, 0, 0, 9, 1, 0, 0); expect_o("post_rst_empty", 0, 0, 0, 0, 0, 0); tick();
    @(negedge clk); #1;
  endtask

  task automatic run_sat();
    @(posedge clk); #1;
    rst_n_sat = 1'b1;
    repeat (310) @(posedge clk);
    #1 sat_q.push_back(16'd300);
    repeat (67700) @(posedge clk);
    #1 sat_q.push_back(16'hFFFF);
    @(negedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish, want finish before 1000000ns");
    $fatal(1, "timeout");
  end

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    fork
      run_main();
      run_sat();
    join
    n_chk++;
    if (sb.size() != 0 || sat_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb.size() + sat_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_unit.md
PIPELINE_HAZARD_UNIT -- requirements
Module: pipeline_hazard_unit

Interface
REQ-001 Parameter ADDR_W, default 5: register address width.
REQ-002 Parameter DEPTH, default 3: number of tracked stages after decode; E[1]=EX, E[2]=MEM, E[3]=WB.
REQ-003 Parameter LOAD_STAGE, default 2: first stage whose output carries load data.
REQ-004 Parameter BRANCH_STAGE, default 2: stage in which a taken branch resolves.
REQ-005 Clk  in  1  single clock; all state updates on rising edge.
REQ-006 Rst  in  1  asynchronous, active-low reset.
REQ-007 id_valid  in  1  decode stage holds a valid instruction.
REQ-008 id_rs, id_rt  in  ADDR_W  source register addresses; id_uses_rs, id_uses_rt  in  1  source actually read.
REQ-009 id_dst  in  ADDR_W  destination; id_reg_write  in  1; id_is_load  in  1.
REQ-010 branch_taken  in  1  taken branch currently in E[BRANCH_STAGE].
REQ-011 stall_if  out  1  hold PC and IF/ID register.
REQ-012 bubble_id  out  1  load zero controls into ID/EX.
REQ-013 flush  out  1  kill all instructions younger than E[BRANCH_STAGE].
REQ-014 fwd_rs_sel, fwd_rt_sel  out  clog2(DEPTH+1)  0 = register file, k = result at output of stage k.
REQ-015 in_flight  out  clog2(DEPTH+1)  count of valid writing entries; stall_cnt  out  16  stall cycles counted.

Function
REQ-016 Tracking state: DEPTH entries {valid, wr, dst, is_load}; wr = id_reg_write and id_dst != 0.
REQ-017 Each cycle E[k+1] <= E[k]; E[1] <= ID instruction if id_valid and not stall_if and not branch_taken, else all-zero bubble.
REQ-018 On branch_taken: entries with index < BRANCH_STAGE become invalid as they shift; E[BRANCH_STAGE] (the branch) shifts normally.
REQ-019 Match: source s (used, s != 0) matches E[k] if valid, wr, dst == s; the lowest k (youngest) wins.
REQ-020 Forward select = matching k, or 0 if no match; combinational from state and ID inputs.
REQ-021 Load-use: matching entry with is_load and k < LOAD_STAGE -> stall_if = bubble_id = 1; forward select driven 0.
REQ-022 Stall holds until the load reaches LOAD_STAGE; default parameters give exactly one bubble cycle.
REQ-023 flush = branch_taken; when flush = 1, stall_if = bubble_id = 0 (flush has priority over stall).
REQ-024 id_valid = 0 -> no stall, selects 0.
REQ-025 Source and destination equal to register 0 never produce a hazard or forward.
REQ-026 in_flight is registered; it equals the count of valid and wr entries after the update.
REQ-027 stall_cnt increments on each cycle with stall_if = 1 and saturates at 0xFFFF (no wrap).

Reset
REQ-028 Rst low clears all entries, in_flight and stall_cnt immediately, without waiting for a clock edge.
REQ-029 During reset: stall_if, bubble_id, flush and selects are 0, whatever the inputs.
REQ-030 Reset during a stall or flush aborts it; first post-reset cycle sees an empty pipeline.

Structure
REQ-031 Shared package holds the entry record type, forward-select encoding constants (SEL_RF = 0) and default parameter values.
REQ-032 One sub-module, hazard_match, instantiated twice (rs, rt): entry vector + source -> select, load_stall.

Verification
REQ-033 add $3 then sub using $3 in the next cycle -> fwd_rs_sel = 1, no stall.
REQ-034 lw $5 then add using $5 -> one cycle stall_if = bubble_id = 1, then fwd sel = 2; stall_cnt = 1.
REQ-035 Writes to $4 in E[1] and E[2], consumer of $4 -> sel = 1 (youngest wins); consumer of $0 after a write to $0 -> sel 0.
REQ-036 branch_taken with lw $5 in E[1] and dependent add in ID -> flush = 1, stall_if = 0; next cycle E[1], E[2] invalid; in_flight counts only the branch.
REQ-037 Rst low mid-stall -> all outputs 0 asynchronously, in_flight = 0; stall_cnt held at 0xFFFF saturates under continuous stalls.
